// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl
//   Initiator side of one single-port cache SRAM macro port. It turns a
//   valid/ready request channel (read, or byte-strobed write) into legal SRAM
//   cycles, returns read data on a valid/ready response channel, and
//   zero-fills the array after reset or on a clear request.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   clr                     re-initialise the whole array (level, sampled in IDLE)
//   init_done               high while idle (array initialised)
//   req_valid/req_ready     request handshake
//   req_write               1 = write, 0 = read
//   req_addr                entry address
//   req_wdata/req_wstrb     write data and active-high byte strobes
//   rsp_valid/rsp_ready     read response handshake
//   rsp_rdata               read data (straight from SRAM Q)
//   sram_addr/cen/wen       SRAM address, active-low chip and write enables
//   sram_wmask              SRAM bit-write enables, active low per bit
//   sram_wdata/sram_rdata   SRAM D and Q
module sram_port_ctrl #(
  parameter int              AW       = 6,
  parameter int              DEPTH    = 64,
  parameter int              DW       = 128,
  parameter logic [DW-1:0]   INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AW-1:0]     req_addr,
  input  logic [DW-1:0]     req_wdata,
  input  logic [DW/8-1:0]   req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_rdata,
  output logic [AW-1:0]     sram_addr,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [DW-1:0]     sram_wmask,
  output logic [DW-1:0]     sram_wdata,
  input  logic [DW-1:0]     sram_rdata
);

  typedef enum logic {
    INIT,
    IDLE
  } state_e;

  localparam logic [AW-1:0] LAST_ENTRY = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          pend;
  logic          accept;

  // State, sweep counter and response-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next-state and SRAM drive. The SRAM outputs are combinational from the
  // state, so they are gated with rst_n: while reset is asserted the state is
  // already INIT, but the macro must see an idle port until release.
  // An unconsumed response blocks every SRAM access, because rsp_rdata is
  // taken directly from Q and Q only holds until the next access.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = 1'b0;
    init_done   = 1'b0;
    accept      = 1'b0;
    sram_cen    = 1'b1;
    sram_wen    = 1'b1;
    sram_wmask  = '1;
    sram_addr   = '0;
    sram_wdata  = '0;
    pend        = rsp_valid_q & ~rsp_ready;

    if (rst_n) begin
      case (state_q)
        INIT: begin
          sram_cen   = 1'b0;
          sram_wen   = 1'b0;
          sram_wmask = '0;
          sram_addr  = cnt_q;
          sram_wdata = INIT_VAL;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LAST_ENTRY) begin
            state_d = IDLE;
          end
        end

        IDLE: begin
          init_done = 1'b1;
          if (clr && !pend) begin
            state_d = INIT;
            cnt_d   = '0;
          end else begin
            req_ready = ~clr & ~pend;
          end

          accept = req_valid & req_ready;
          if (accept) begin
            sram_cen  = 1'b0;
            sram_addr = req_addr;
            if (req_write) begin
              sram_wen   = 1'b0;
              sram_wdata = req_wdata;
              // A zero strobe still issues the cycle; its mask bits stay high.
              for (int j = 0; j < DW/8; j++) begin
                sram_wmask[8*j +: 8] = {8{~req_wstrb[j]}};
              end
            end
          end

          // A read accepted in the same cycle as a consumed response keeps
          // rsp_valid high for the back-to-back case.
          if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
          end
          if (accept && !req_write) begin
            rsp_valid_d = 1'b1;
          end
        end

        default: begin
          state_d = INIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl
//   Directed bench for sram_port_ctrl with a behavioural single-port SRAM
//   (1-cycle read latency, per-bit active-low write mask, Q holds otherwise).
module tb_sram_port_ctrl;

  localparam int AW = 6;
  localparam int DW = 128;

  localparam logic [127:0] DATA_A = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DATA_P = 128'hDEADBEEFCAFEF00D1122334455667788;
  localparam logic [127:0] ONES   = {128{1'b1}};

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          initDone;
  logic          reqValid;
  logic          reqReady;
  logic          reqWrite;
  logic [5:0]    reqAddr;
  logic [127:0]  reqWdata;
  logic [15:0]   reqWstrb;
  logic          rspValid;
  logic          rspReady;
  logic [127:0]  rspRdata;
  logic [5:0]    sramAddr;
  logic          sramCen;
  logic          sramWen;
  logic [127:0]  sramWmask;
  logic [127:0]  sramWdata;
  logic [127:0]  sramRdata;

  int total = 0;
  int bad   = 0;

  // One directed vector: inputs for a cycle and the outputs expected in it.
  typedef struct packed {
    logic         valid;
    logic         write;
    logic [5:0]   addr;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         rspReady;
    logic         clr;
    logic         expReady;
    logic         expCen;
    logic         expWen;
    logic [127:0] expWmask;
    logic         expRspValid;
    logic         chkData;
    logic [127:0] expRdata;
    logic         expInitDone;
  } vecT;

  vecT vecs[13];

  sram_port_ctrl #(
    .AW(AW), .DEPTH(64), .DW(DW), .INIT_VAL('0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .init_done  (initDone),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_write  (reqWrite),
    .req_addr   (reqAddr),
    .req_wdata  (reqWdata),
    .req_wstrb  (reqWstrb),
    .rsp_valid  (rspValid),
    .rsp_ready  (rspReady),
    .rsp_rdata  (rspRdata),
    .sram_addr  (sramAddr),
    .sram_cen   (sramCen),
    .sram_wen   (sramWen),
    .sram_wmask (sramWmask),
    .sram_wdata (sramWdata),
    .sram_rdata (sramRdata)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM macro; starts full of garbage so the zero-fill shows.
  logic [127:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    sramRdata = {$urandom, $urandom, $urandom, $urandom};
  end

  always @(posedge clk) begin
    if (!sramCen) begin
      if (!sramWen) begin
        mem[sramAddr] <= (mem[sramAddr] & sramWmask) | (sramWdata & ~sramWmask);
      end else begin
        sramRdata <= mem[sramAddr];
      end
    end
  end

  // Safety net: the directed sequence is a few hundred cycles long.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vecT mkVec(
    input logic valid, input logic write, input logic [5:0] addr,
    input logic [127:0] wdata, input logic [15:0] wstrb,
    input logic rspRdy, input logic clrIn,
    input logic expReady, input logic expCen, input logic expWen,
    input logic [127:0] expWmask, input logic expRspValid,
    input logic chkData, input logic [127:0] expRdata, input logic expInitDone);
    vecT v;
    v.valid = valid;       v.write = write;       v.addr = addr;
    v.wdata = wdata;       v.wstrb = wstrb;       v.rspReady = rspRdy;
    v.clr = clrIn;         v.expReady = expReady; v.expCen = expCen;
    v.expWen = expWen;     v.expWmask = expWmask; v.expRspValid = expRspValid;
    v.chkData = chkData;   v.expRdata = expRdata; v.expInitDone = expInitDone;
    return v;
  endfunction

  task automatic applyStimulus(input vecT v);
    reqValid = v.valid;
    reqWrite = v.write;
    reqAddr  = v.addr;
    reqWdata = v.wdata;
    reqWstrb = v.wstrb;
    rspReady = v.rspReady;
    clr      = v.clr;
  endtask

  // Address and write data are only meaningful on an active cycle; idle
  // cycles must show zero on both.
  task automatic checkOutput(input string tag, input vecT v);
    logic [127:0] expAddr;
    logic [127:0] expWdata;
    expAddr  = v.expCen ? 128'd0 : {122'd0, v.addr};
    expWdata = (!v.expCen && !v.expWen) ? v.wdata : 128'd0;
    check({tag, " req_ready"},  {127'd0, reqReady}, {127'd0, v.expReady});
    check({tag, " sram_cen"},   {127'd0, sramCen},  {127'd0, v.expCen});
    check({tag, " sram_wen"},   {127'd0, sramWen},  {127'd0, v.expWen});
    check({tag, " sram_wmask"}, sramWmask, v.expWmask);
    check({tag, " sram_addr"},  {122'd0, sramAddr}, expAddr);
    check({tag, " sram_wdata"}, sramWdata, expWdata);
    check({tag, " rsp_valid"},  {127'd0, rspValid}, {127'd0, v.expRspValid});
    check({tag, " init_done"},  {127'd0, initDone}, {127'd0, v.expInitDone});
    if (v.chkData) begin
      check({tag, " rsp_rdata"}, rspRdata, v.expRdata);
    end
  endtask

  // Called one time unit after a rising edge; leaves at the same point of
  // the next cycle.
  task automatic runVec(input string tag, input vecT v);
    applyStimulus(v);
    #1;
    checkOutput(tag, v);
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    #1;
    check({tag, " sram_cen"},   {127'd0, sramCen},   128'd1);
    check({tag, " sram_wen"},   {127'd0, sramWen},   128'd1);
    check({tag, " sram_wmask"}, sramWmask,           ONES);
    check({tag, " sram_addr"},  {122'd0, sramAddr},  128'd0);
    check({tag, " sram_wdata"}, sramWdata,           128'd0);
    check({tag, " req_ready"},  {127'd0, reqReady},  128'd0);
    check({tag, " rsp_valid"},  {127'd0, rspValid},  128'd0);
    check({tag, " init_done"},  {127'd0, initDone},  128'd0);
  endtask

  // Checks nCycles sweep cycles starting at entry 0, with a read request and
  // clr held high to show both are ignored while initialising.
  task automatic runSweep(input string tag, input int nCycles);
    for (int i = 0; i < nCycles; i++) begin
      reqValid = 1'b1;
      reqWrite = 1'b0;
      reqAddr  = 6'd40;
      rspReady = 1'b1;
      clr      = (i < 60);
      #1;
      check($sformatf("%s[%0d] sram_cen", tag, i),   {127'd0, sramCen},  128'd0);
      check($sformatf("%s[%0d] sram_wen", tag, i),   {127'd0, sramWen},  128'd0);
      check($sformatf("%s[%0d] sram_wmask", tag, i), sramWmask,          128'd0);
      check($sformatf("%s[%0d] sram_addr", tag, i),  {122'd0, sramAddr}, 128'(i));
      check($sformatf("%s[%0d] sram_wdata", tag, i), sramWdata,          128'd0);
      check($sformatf("%s[%0d] req_ready", tag, i),  {127'd0, reqReady}, 128'd0);
      check($sformatf("%s[%0d] init_done", tag, i),  {127'd0, initDone}, 128'd0);
      check($sformatf("%s[%0d] rsp_valid", tag, i),  {127'd0, rspValid}, 128'd0);
      @(posedge clk);
      #1;
    end
    reqValid = 1'b0;
    clr      = 1'b0;
  endtask

  // Main directed sequence.
  initial begin
    // Table of single-cycle IDLE vectors, run right after the first sweep.
    //              vld wr addr   wdata   wstrb     rr clr  rdy cen wen wmask         rv chk rdata   idn
    vecs[0]  = mkVec(1, 0, 6'd17, '0,     16'h0000, 1, 0,   1,  0,  1,  ONES,         0, 0,  '0,     1);
    vecs[1]  = mkVec(1, 1, 6'd5,  DATA_A, 16'hFFFF, 1, 0,   1,  0,  0,  '0,           1, 1,  '0,     1);
    vecs[2]  = mkVec(1, 0, 6'd5,  '0,     16'h0000, 1, 0,   1,  0,  1,  ONES,         0, 0,  '0,     1);
    vecs[3]  = mkVec(1, 1, 6'd9,  ONES,   16'h0001, 1, 0,   1,  0,  0,  ~128'hFF,     1, 1,  DATA_A, 1);
    vecs[4]  = mkVec(1, 0, 6'd9,  '0,     16'h0000, 1, 0,   1,  0,  1,  ONES,         0, 0,  '0,     1);
    vecs[5]  = mkVec(0, 0, 6'd0,  '0,     16'h0000, 1, 0,   1,  1,  1,  ONES,         1, 1,  128'hFF,1);
    vecs[6]  = mkVec(1, 1, 6'd12, ONES,   16'h0000, 1, 0,   1,  0,  0,  ONES,         0, 0,  '0,     1);
    vecs[7]  = mkVec(1, 0, 6'd12, '0,     16'h0000, 1, 0,   1,  0,  1,  ONES,         0, 0,  '0,     1);
    vecs[8]  = mkVec(1, 1, 6'd3,  DATA_P, 16'hFFFF, 1, 0,   1,  0,  0,  '0,           1, 1,  '0,     1);
    vecs[9]  = mkVec(0, 0, 6'd0,  '0,     16'h0000, 1, 0,   1,  1,  1,  ONES,         0, 0,  '0,     1);
    vecs[10] = mkVec(1, 0, 6'd5,  '0,     16'h0000, 1, 0,   1,  0,  1,  ONES,         0, 0,  '0,     1);
    vecs[11] = mkVec(1, 0, 6'd9,  '0,     16'h0000, 1, 0,   1,  0,  1,  ONES,         1, 1,  DATA_A, 1);
    vecs[12] = mkVec(0, 0, 6'd0,  '0,     16'h0000, 1, 0,   1,  1,  1,  ONES,         1, 1,  128'hFF,1);

    rst_n    = 1'b0;
    clr      = 1'b0;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqAddr  = '0;
    reqWdata = '0;
    reqWstrb = '0;
    rspReady = 1'b1;

    // Reset, then the full zero-fill sweep.
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    rst_n = 1'b1;
    runSweep("sweep0", 64);

    for (int i = 0; i < 13; i++) begin
      runVec($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-pressure: a pending response blocks new requests and SRAM access.
    runVec("stall0", mkVec(1, 0, 6'd3, '0, '0, 0, 0, 1, 0, 1, ONES, 0, 0, '0, 1));
    for (int i = 1; i <= 4; i++) begin
      runVec($sformatf("stall%0d", i),
             mkVec(1, 0, 6'd7, '0, '0, 0, 0, 0, 1, 1, ONES, 1, 1, DATA_P, 1));
    end
    runVec("stall5", mkVec(1, 0, 6'd7, '0, '0, 1, 0, 1, 0, 1, ONES, 1, 1, DATA_P, 1));
    runVec("stall6", mkVec(0, 0, 6'd0, '0, '0, 1, 0, 1, 1, 1, ONES, 1, 1, '0, 1));

    // Clear while a response is pending: no re-init until it is consumed.
    runVec("clr0", mkVec(1, 0, 6'd5, '0, '0, 0, 0, 1, 0, 1, ONES, 0, 0, '0, 1));
    runVec("clr1", mkVec(1, 0, 6'd7, '0, '0, 0, 1, 0, 1, 1, ONES, 1, 1, DATA_A, 1));
    runVec("clr2", mkVec(1, 0, 6'd7, '0, '0, 0, 1, 0, 1, 1, ONES, 1, 1, DATA_A, 1));
    runVec("clr3", mkVec(1, 0, 6'd7, '0, '0, 1, 1, 0, 1, 1, ONES, 1, 1, DATA_A, 1));
    runSweep("sweep1", 64);
    runVec("clr4", mkVec(1, 0, 6'd5, '0, '0, 1, 0, 1, 0, 1, ONES, 0, 0, '0, 1));
    runVec("clr5", mkVec(0, 0, 6'd0, '0, '0, 1, 0, 1, 1, 1, ONES, 1, 1, '0, 1));

    // Reset with a response pending, then again in the middle of the sweep.
    runVec("rst0", mkVec(1, 0, 6'd3, '0, '0, 0, 0, 1, 0, 1, ONES, 0, 0, '0, 1));
    reqValid = 1'b0;
    rst_n    = 1'b0;
    checkReset("rstPend");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    runSweep("sweep2", 30);
    rst_n = 1'b0;
    checkReset("rstMid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    runSweep("sweep3", 64);
    runVec("rst1", mkVec(1, 0, 6'd3, '0, '0, 1, 0, 1, 0, 1, ONES, 0, 0, '0, 1));
    runVec("rst2", mkVec(0, 0, 6'd0, '0, '0, 1, 0, 1, 1, 1, ONES, 1, 1, '0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
